// File: rtl/shader_mem_sequencer.sv
// shader_mem_sequencer: shares the circular instruction ring between SPI word loads and
// per-pixel shader sweeps, realigning the ring head to index 0 before every sweep.
module shader_mem_sequencer #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     pixel_start_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     wr_rewind_i,
    input  logic [WIDTH-1:0]         mem_head_i,
    output logic                     mem_shift_o,
    output logic                     mem_load_o,
    output logic [WIDTH-1:0]         mem_data_o,
    output logic                     exec_valid_o,
    output logic [WIDTH-1:0]         exec_instr_o,
    output logic                     exec_last_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH)-1:0] head_idx_o,
    output logic                     overrun_o
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_EXEC} state_t;
    state_t           r_state, w_state_nxt;
    logic             r_pend, w_pend_nxt;
    logic [AW-1:0]    r_head, w_head_nxt;
    logic             r_shift, r_load, r_valid, r_last, r_ovr;
    logic [WIDTH-1:0] r_data;
    logic             w_wr_ready, w_wr_acc;
    // Head index as it will be after this cycle's shift (if any) lands.
    assign w_head_nxt = r_head + AW'(r_shift);
    assign w_wr_ready = (r_state == S_IDLE) && !pixel_start_i && !wr_rewind_i;
    assign w_wr_acc   = wr_valid_i && w_wr_ready;
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        case (r_state)
            S_IDLE: begin
                if (pixel_start_i) begin
                    w_state_nxt = (w_head_nxt == '0) ? S_EXEC : S_ALIGN;
                    w_pend_nxt  = 1'b1;
                end else if (wr_rewind_i && (w_head_nxt != '0)) begin
                    w_state_nxt = S_ALIGN;
                    w_pend_nxt  = 1'b0;
                end
            end
            S_ALIGN: begin
                w_pend_nxt = r_pend || pixel_start_i;
                if (w_head_nxt == '0) w_state_nxt = w_pend_nxt ? S_EXEC : S_IDLE;
            end
            S_EXEC: begin
                if (w_head_nxt == '0) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_state_nxt != S_ALIGN) w_pend_nxt = 1'b0;
    end
    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_pend  <= 1'b0;
            r_head  <= '0;
            r_shift <= 1'b0;
            r_load  <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            r_head  <= w_head_nxt;
            r_shift <= (w_state_nxt != S_IDLE) || w_wr_acc;
            r_load  <= w_wr_acc;
            r_data  <= w_wr_acc ? wr_data_i : '0;
            r_valid <= (w_state_nxt == S_EXEC);
            r_last  <= (w_state_nxt == S_EXEC) && (w_head_nxt == AW'(DEPTH - 1));
            r_ovr   <= r_ovr || ((r_state == S_EXEC) && pixel_start_i);
        end
    end
    assign wr_ready_o   = w_wr_ready;
    assign mem_shift_o  = r_shift;
    assign mem_load_o   = r_load;
    assign mem_data_o   = r_data;
    assign exec_valid_o = r_valid;
    assign exec_instr_o = r_valid ? mem_head_i : '0;
    assign exec_last_o  = r_last;
    assign busy_o       = (r_state != S_IDLE);
    assign head_idx_o   = r_head;
    assign overrun_o    = r_ovr;
endmodule
